// File: rtl/rd_pkg.sv
// Shared types for the popcount pipeline: beat modes, token flags and the
// count-width helper used by both the combinational core and the pipe.
package rd_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_PARITY = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_ACCUM  = 2'd3
    } mode_e;

    // Flag half of a pipeline token; the count half is sized by ACC_W inside the pipe.
    typedef struct packed {
        logic parity;
        logic thr;
        logic sat;
        logic err;
    } tok_flags_t;

    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/rd_popcount_comb.sv
// Purely combinational population count and parity of one word, built as a
// balanced adder tree so it can be NOR-mapped and checked against rd53 alone.
module rd_popcount_comb
    import rd_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CW    = calc_cw(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             parity
);

    localparam int LOG    = $clog2(WIDTH);
    localparam int LEAVES = 1 << LOG;

    // Level 0 holds the input bits padded with zeros to a power of two;
    // each further level halves the node count by pairwise addition.
    for (genvar l = 0; l <= LOG; l++) begin : g_lvl
        localparam int N = LEAVES >> l;
        logic [CW-1:0] sum [N];
        for (genvar i = 0; i < N; i++) begin : g_n
            if (l == 0) begin : g_leaf
                if (i < WIDTH) begin : g_bit
                    assign sum[i] = CW'(data[i]);
                end else begin : g_pad
                    assign sum[i] = '0;
                end
            end else begin : g_add
                assign sum[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
            end
        end
    end

    assign count  = g_lvl[LOG].sum[0];
    assign parity = ^data;

endmodule

// File: rtl/rd_popcount_pipe.sv
// Pipelined popcount with parity/threshold flags and multi-beat accumulation
// on a valid/ready stream; STAGES register slices with per-stage valid bits.
module rd_popcount_pipe
    import rd_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2,
    parameter int ACC_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [ACC_W-1:0] in_thr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_parity,
    output logic             out_thr,
    output logic             out_sat,
    output logic             out_err
);

    localparam int CW = calc_cw(WIDTH);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef struct packed {
        logic [ACC_W-1:0] count;
        tok_flags_t       flags;
    } token_t;

    logic [CW-1:0] beat_count;
    logic          beat_parity;

    rd_popcount_comb #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_comb (
        .data   (in_data),
        .count  (beat_count),
        .parity (beat_parity)
    );

    mode_e mode;
    assign mode = mode_e'(in_mode);

    logic [ACC_W-1:0] acc;
    logic             acc_parity;
    logic             acc_sat;
    logic             in_progress;

    logic [ACC_W-1:0] count_ext;
    logic [ACC_W-1:0] base_acc;
    logic [ACC_W:0]   sum_wide;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;
    logic             acc_parity_next;
    logic             acc_sat_next;

    // Accumulator state is masked by in_progress so a new packet always starts from zero.
    always_comb begin
        count_ext       = ACC_W'(beat_count);
        base_acc        = in_progress ? acc : '0;
        sum_wide        = {1'b0, base_acc} + {1'b0, count_ext};
        sum_ovf         = sum_wide[ACC_W];
        sum_sat         = sum_ovf ? ACC_MAX : sum_wide[ACC_W-1:0];
        acc_parity_next = (in_progress & acc_parity) ^ beat_parity;
        acc_sat_next    = (in_progress & acc_sat) | sum_ovf;
    end

    token_t new_tok;

    always_comb begin
        new_tok = '0;
        if (mode == MODE_ACCUM) begin
            new_tok.count        = sum_sat;
            new_tok.flags.parity = acc_parity_next;
            new_tok.flags.thr    = (sum_sat >= in_thr);
            new_tok.flags.sat    = acc_sat_next;
        end else begin
            new_tok.count        = count_ext;
            new_tok.flags.parity = beat_parity;
            new_tok.flags.thr    = (count_ext >= in_thr);
            new_tok.flags.err    = in_progress;
        end
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES:0]   free;
    token_t            tok [STAGES];

    // free[k]: stage k can take a new token this cycle; free[STAGES] is the consumer.
    always_comb begin
        adv          = '0;
        free         = '0;
        free[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = vld[k] && free[k+1];
            free[k] = !vld[k] || adv[k];
        end
    end

    logic accept;
    logic inject;

    assign in_ready = free[0];
    assign accept   = in_valid && in_ready;
    assign inject   = accept && ((mode != MODE_ACCUM) || in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tok[k] <= '0;
            end
        end else begin
            if (free[0]) begin
                vld[0] <= inject;
                if (inject) begin
                    tok[0] <= new_tok;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (free[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        tok[k] <= tok[k-1];
                    end
                end
            end
        end
    end

    // Only non-last ACCUM beats keep the packet open; anything else closes or aborts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            acc_parity  <= 1'b0;
            acc_sat     <= 1'b0;
            in_progress <= 1'b0;
        end else if (accept) begin
            if ((mode == MODE_ACCUM) && !in_last) begin
                acc         <= sum_sat;
                acc_parity  <= acc_parity_next;
                acc_sat     <= acc_sat_next;
                in_progress <= 1'b1;
            end else begin
                acc         <= '0;
                acc_parity  <= 1'b0;
                acc_sat     <= 1'b0;
                in_progress <= 1'b0;
            end
        end
    end

    assign out_valid  = vld[STAGES-1];
    assign out_count  = tok[STAGES-1].count;
    assign out_parity = tok[STAGES-1].flags.parity;
    assign out_thr    = tok[STAGES-1].flags.thr;
    assign out_sat    = tok[STAGES-1].flags.sat;
    assign out_err    = tok[STAGES-1].flags.err;

endmodule

// File: tb/tb_rd_popcount_pipe.sv
// Scoreboard bench for rd_popcount_pipe: driver pushes expected results from a
// packet-level reference model, an independent monitor pops on each transfer.
module tb_rd_popcount_pipe;

    localparam int WIDTH   = 5;
    localparam int STAGES  = 2;
    localparam int ACC_W   = 4;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [ACC_W-1:0] in_thr;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_parity;
    logic             out_thr;
    logic             out_sat;
    logic             out_err;

    always #5 clk = ~clk;

    rd_popcount_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .ACC_W  (ACC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_thr     (in_thr),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_parity (out_parity),
        .out_thr    (out_thr),
        .out_sat    (out_sat),
        .out_err    (out_err)
    );

    typedef struct {
        int count;
        bit parity;
        bit thr;
        bit sat;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference: a packet is just the running total of ones seen so far.
    int   pkt_total  = 0;
    bit   pkt_active = 0;

    int   or_mode   = 1;   // 0 random, 1 always ready, 2 held low
    bit   guard     = 1;
    bit   saw_stall = 0;

    task automatic model_accept(input int mode, input logic [WIDTH-1:0] data,
                                input int thr, input bit last);
        int   c;
        exp_t e;
        c = $countones(data);
        if (mode == 3) begin
            pkt_total += c;
            pkt_active = 1;
            if (last) begin
                e.count  = (pkt_total > ACC_MAX) ? ACC_MAX : pkt_total;
                e.parity = (pkt_total % 2) != 0;
                e.sat    = pkt_total > ACC_MAX;
                e.thr    = e.count >= thr;
                e.err    = 0;
                exp_q.push_back(e);
                pkt_total  = 0;
                pkt_active = 0;
            end
        end else begin
            e.count  = c;
            e.parity = (c % 2) != 0;
            e.thr    = c >= thr;
            e.sat    = 0;
            e.err    = pkt_active;
            exp_q.push_back(e);
            pkt_total  = 0;
            pkt_active = 0;
        end
    endtask

    task automatic send(input int mode, input logic [WIDTH-1:0] data,
                        input int thr, input bit last);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = 2'(mode);
        in_data  = data;
        in_thr   = ACC_W'(thr);
        in_last  = last;
        #1;
        while (!in_ready) begin
            saw_stall = 1;
            waited++;
            if (waited > 1000) begin
                n_vec++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        model_accept(mode, data, thr, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, got, want);
        end
    endtask

    task automatic do_reset();
        or_mode = 2;
        guard   = 1;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        pkt_total  = 0;
        pkt_active = 0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        or_mode = 1;
        #2;
        check_bit("rst_no_out_c0", out_valid, 1'b0);
        @(negedge clk);
        #2;
        check_bit("rst_no_out_c1", out_valid, 1'b0);
        guard = 0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (or_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t             e;
        bit               prev_stall;
        logic [ACC_W-1:0] p_count;
        logic [4:0]       p_flags;
        prev_stall = 0;
        p_count    = '0;
        p_flags    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (guard) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (!(out_valid === 1'b1 && out_count === p_count &&
                          {out_parity, out_thr, out_sat, out_err} === p_flags[3:0])) begin
                        n_fail++;
                        $display("FAIL hold_stable: got valid=%0b count=%0d flags=%b, required valid=1 count=%0d flags=%b",
                                 out_valid, out_count, {out_parity, out_thr, out_sat, out_err},
                                 p_count, p_flags[3:0]);
                    end
                end
                prev_stall = out_valid && !out_ready;
                p_count    = out_count;
                p_flags    = {1'b0, out_parity, out_thr, out_sat, out_err};
                if (out_valid && out_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_result: got count=%0d, required no output", out_count);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_count !== ACC_W'(e.count) || out_parity !== e.parity ||
                            out_thr !== e.thr || out_sat !== e.sat || out_err !== e.err) begin
                            n_fail++;
                            $display("FAIL result: got count=%0d par=%0b thr=%0b sat=%0b err=%0b, required count=%0d par=%0b thr=%0b sat=%0b err=%0b",
                                     out_count, out_parity, out_thr, out_sat, out_err,
                                     e.count, e.parity, e.thr, e.sat, e.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int waited;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 2'd0;
        in_thr   = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        n_vec++;
        if ({out_count, out_parity, out_thr, out_sat, out_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got count=%0d flags=%b, required all zero",
                     out_count, {out_parity, out_thr, out_sat, out_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        idle(2);

        // Latency: result visible exactly STAGES cycles after acceptance.
        send(0, 5'b10110, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check_bit("latency_t1", out_valid, 1'b0);
        @(negedge clk);
        #2;
        check_bit("latency_t2", out_valid, 1'b1);
        idle(3);

        send(2, 5'b11111, 5, 0);
        send(2, 5'b11110, 5, 0);
        idle(3);

        send(3, 5'b11111, 0, 0);
        send(3, 5'b00001, 0, 0);
        send(3, 5'b10100, 9, 1);
        idle(3);

        repeat (3) send(3, 5'b11111, 0, 0);
        send(3, 5'b11111, 15, 1);
        idle(3);

        repeat (2) send(3, 5'b11111, 0, 0);
        send(3, 5'b11111, 15, 1);
        idle(4);

        // Backpressure: six back-to-back beats with the consumer stalled.
        saw_stall = 0;
        fork
            begin
                or_mode = 2;
                repeat (5) @(negedge clk);
                or_mode = 1;
            end
            begin
                send(0, 5'b00000, 1, 0);
                send(0, 5'b00001, 1, 0);
                send(0, 5'b00011, 2, 0);
                send(0, 5'b00111, 4, 0);
                send(0, 5'b01111, 4, 1);
                send(0, 5'b11111, 5, 0);
            end
        join
        idle(6);
        check_bit("bp_in_ready_drop", saw_stall, 1'b1);

        send(3, 5'b00111, 0, 0);
        send(0, 5'b00001, 1, 0);
        idle(4);

        send(3, 5'b11100, 0, 0);
        do_reset();
        send(3, 5'b00011, 2, 1);
        idle(4);

        // Randomised traffic with random backpressure and one mid-run reset.
        or_mode = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            int mode;
            if (i == 200) begin
                do_reset();
                or_mode = 0;
            end
            r    = $urandom_range(0, 5);
            mode = (r >= 3) ? 3 : r;
            send(mode, WIDTH'($urandom), $urandom_range(0, ACC_MAX),
                 ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        or_mode = 1;
        idle(1);
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        idle(3);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
